// File: rtl/riscv_pkg.sv
// Shared RISC-V MDU definitions: FSM encoding, M-extension funct3 codes and latency defaults.
package riscv_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MDU_XLEN_DEFAULT    = 64;
    localparam int MDU_MUL_LAT_DEFAULT = 2;
    localparam int MDU_DIV_LAT_DEFAULT = 64;

    function automatic logic f3_is_mul(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
    endfunction

    function automatic logic f3_is_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/riscv_mdu_special.sv
// Detects divides whose answer is fixed by the ISA (divide by zero, signed overflow) and
// supplies that answer; purely combinational, result is pre-sign-extension for W-ops.
module riscv_mdu_special
    import riscv_pkg::*;
#(
    parameter int XLEN = MDU_XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            hit,
    output logic [XLEN-1:0] result
);

    logic div_zero;
    logic rs1_min;
    logic rs2_neg1;
    logic is_signed;
    logic is_rem;
    logic overflow;

    always_comb begin
        is_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
        is_rem    = (funct3 == F3_REM) || (funct3 == F3_REMU);
        if (word) begin
            div_zero = (rs2[31:0] == 32'd0);
            rs1_min  = (rs1[31:0] == 32'h8000_0000);
            rs2_neg1 = &rs2[31:0];
        end else begin
            div_zero = (rs2 == '0);
            rs1_min  = (rs1 == {1'b1, {(XLEN-1){1'b0}}});
            rs2_neg1 = &rs2;
        end
        overflow = is_signed && rs1_min && rs2_neg1;
        hit      = f3_is_div(funct3) && (div_zero || overflow);
        if (div_zero) begin
            result = is_rem ? rs1 : '1;
        end else begin
            result = is_rem ? '0 : rs1;
        end
    end

endmodule

// File: rtl/riscv_mdu_ctrl.sv
// Sequencer for the shared mul/div datapath; RISCV_MDU_EARLYOUT_EN resolves trivial divides in-house.
// Latency: request to valid = LAT+1 cycles (DIV_LAT/2 for W divides, 2 cycles for an early-out).
// Backpressure: globstall only holds DONE (valid + result); the op counter never stalls.
module riscv_mdu_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN    = MDU_XLEN_DEFAULT,
    parameter int MUL_LAT = MDU_MUL_LAT_DEFAULT,
    parameter int DIV_LAT = MDU_DIV_LAT_DEFAULT
) (
    input  logic            i_riscv_mdu_clk,
    input  logic            i_riscv_mdu_rst,
    input  logic            i_riscv_mdu_mul_en,
    input  logic            i_riscv_mdu_div_en,
    input  logic [2:0]      i_riscv_mdu_funct3,
    input  logic            i_riscv_mdu_word,
    input  logic [XLEN-1:0] i_riscv_mdu_rs1,
    input  logic [XLEN-1:0] i_riscv_mdu_rs2,
    input  logic            i_riscv_mdu_flush,
    input  logic            i_riscv_mdu_globstall,
    input  logic [XLEN-1:0] i_riscv_mdu_dp_result,
    output logic            o_riscv_mdu_dp_start,
    output logic            o_riscv_mdu_dp_seldiv,
    output logic            o_riscv_mdu_valid,
    output logic            o_riscv_mdu_busy,
    output logic [XLEN-1:0] o_riscv_mdu_result
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

`ifdef RISCV_MDU_EARLYOUT_EN
    localparam bit EARLYOUT = 1'b1;
`else
    localparam bit EARLYOUT = 1'b0;
`endif

    mdu_state_e      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_funct3;
    logic            op_word;
    logic [XLEN-1:0] op_rs1;
    logic [XLEN-1:0] op_rs2;
    logic            start_q;
    logic            sp_hit;
    logic [XLEN-1:0] sp_result;
    logic            early_hit;

    riscv_mdu_special #(.XLEN(XLEN)) u_special (
        .funct3 (op_funct3),
        .word   (op_word),
        .rs1    (op_rs1),
        .rs2    (op_rs2),
        .hit    (sp_hit),
        .result (sp_result)
    );

    // The first DIV cycle looks at the latched operands and suppresses the start pulse
    // when the answer is already known.
    assign early_hit            = EARLYOUT && start_q && (state == MDU_DIV) && sp_hit;
    assign o_riscv_mdu_dp_start = start_q && !early_hit;

    function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] r, input logic w);
        logic [XLEN-1:0] f;
        f = r;
        if (w) begin
            for (int i = 32; i < XLEN; i++) f[i] = r[31];
        end
        return f;
    endfunction

    always_ff @(posedge i_riscv_mdu_clk) begin
        if (i_riscv_mdu_rst) begin
            state                 <= MDU_IDLE;
            cnt                   <= '0;
            o_riscv_mdu_result    <= '0;
            o_riscv_mdu_valid     <= 1'b0;
            o_riscv_mdu_busy      <= 1'b0;
            o_riscv_mdu_dp_seldiv <= 1'b0;
            start_q               <= 1'b0;
        end else if (i_riscv_mdu_flush) begin
            state                 <= MDU_IDLE;
            cnt                   <= '0;
            o_riscv_mdu_valid     <= 1'b0;
            o_riscv_mdu_busy      <= 1'b0;
            o_riscv_mdu_dp_seldiv <= 1'b0;
            start_q               <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (i_riscv_mdu_mul_en || i_riscv_mdu_div_en) begin
                        op_funct3        <= i_riscv_mdu_funct3;
                        op_word          <= i_riscv_mdu_word;
                        op_rs1           <= i_riscv_mdu_rs1;
                        op_rs2           <= i_riscv_mdu_rs2;
                        start_q          <= 1'b1;
                        o_riscv_mdu_busy <= 1'b1;
                        if (i_riscv_mdu_div_en) begin
                            state                 <= MDU_DIV;
                            o_riscv_mdu_dp_seldiv <= 1'b1;
                            cnt <= i_riscv_mdu_word ? CW'(DIV_LAT / 2) : CW'(DIV_LAT);
                        end else begin
                            state                 <= MDU_MUL;
                            o_riscv_mdu_dp_seldiv <= 1'b0;
                            cnt                   <= CW'(MUL_LAT);
                        end
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    if (early_hit) begin
                        o_riscv_mdu_result <= fmt_result(sp_result, op_word);
                        cnt                <= '0;
                        state              <= MDU_DONE;
                        o_riscv_mdu_busy   <= 1'b0;
                        o_riscv_mdu_valid  <= 1'b1;
                    end else begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            o_riscv_mdu_result <= fmt_result(i_riscv_mdu_dp_result, op_word);
                            state              <= MDU_DONE;
                            o_riscv_mdu_busy   <= 1'b0;
                            o_riscv_mdu_valid  <= 1'b1;
                        end
                    end
                end
                MDU_DONE: begin
                    if (!i_riscv_mdu_globstall) begin
                        state                 <= MDU_IDLE;
                        o_riscv_mdu_valid     <= 1'b0;
                        o_riscv_mdu_dp_seldiv <= 1'b0;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mdu_ctrl.sv
// Scoreboard bench for riscv_mdu_ctrl: an arithmetic reference model predicts result and arrival
// cycle; a negedge monitor pops and compares whenever valid rises. Honours RISCV_MDU_EARLYOUT_EN.
module tb_riscv_mdu_ctrl;
    import riscv_pkg::*;

    localparam int XLEN    = 64;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 64;
`ifdef RISCV_MDU_EARLYOUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, mul_en, div_en, word, flush, globstall;
    logic [2:0]  funct3;
    logic [63:0] rs1, rs2, dp_result;
    logic        dp_start, dp_seldiv, valid, busy;
    logic [63:0] result;

    riscv_mdu_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_riscv_mdu_clk       (clk),
        .i_riscv_mdu_rst       (rst),
        .i_riscv_mdu_mul_en    (mul_en),
        .i_riscv_mdu_div_en    (div_en),
        .i_riscv_mdu_funct3    (funct3),
        .i_riscv_mdu_word      (word),
        .i_riscv_mdu_rs1       (rs1),
        .i_riscv_mdu_rs2       (rs2),
        .i_riscv_mdu_flush     (flush),
        .i_riscv_mdu_globstall (globstall),
        .i_riscv_mdu_dp_result (dp_result),
        .o_riscv_mdu_dp_start  (dp_start),
        .o_riscv_mdu_dp_seldiv (dp_seldiv),
        .o_riscv_mdu_valid     (valid),
        .o_riscv_mdu_busy      (busy),
        .o_riscv_mdu_result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] res;
        int          vcyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] last_res = 64'd0;
    logic [63:0] held_res = 64'd0;
    bit          prev_valid = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // ISA-level arithmetic for every M-extension op the bench issues.
    function automatic logic [63:0] ref_op(input bit is_div, input logic [2:0] f3, input bit w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        logic [63:0]  q64, r64, res;
        logic [31:0]  a32, b32, q32, r32;
        bit           sgn;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        res = 64'd0;
        if (!is_div) begin
            case (f3[1:0])
                2'd0: begin p = ua * ub; res = w ? sx32(p[31:0]) : p[63:0]; end
                2'd1: begin p = sa * sb; res = p[127:64]; end
                2'd2: begin p = sa * ub; res = p[127:64]; end
                default: begin p = ua * ub; res = p[127:64]; end
            endcase
        end else begin
            sgn = !f3[0];
            if (w) begin
                a32 = a[31:0];
                b32 = b[31:0];
                if (b32 == 32'd0) begin
                    q32 = 32'hFFFF_FFFF; r32 = a32;
                end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                    q32 = a32; r32 = 32'd0;
                end else if (sgn) begin
                    q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32; r32 = a32 % b32;
                end
                res = sx32(f3[1] ? r32 : q32);
            end else begin
                if (b == 64'd0) begin
                    q64 = '1; r64 = a;
                end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    q64 = a; r64 = 64'd0;
                end else if (sgn) begin
                    q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
                end else begin
                    q64 = a / b; r64 = a % b;
                end
                res = f3[1] ? r64 : q64;
            end
        end
        return res;
    endfunction

    function automatic bit is_trivial_div(input bit is_div, input logic [2:0] f3, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
        bit zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        return is_div && (zero || ovf);
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = {$urandom, 32'h8000_0000};
            4:       v = 64'($urandom_range(0, 50));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issues one op, plays the datapath, holds DONE for `stall` cycles, returns in the IDLE cycle.
    task automatic run_op(input bit is_div, input logic [2:0] f3, input bit w,
                          input logic [63:0] a, input logic [63:0] b, input int stall, input string nm);
        logic [63:0] expv;
        bit          early;
        int          lat;
        exp_t        e;
        expv  = ref_op(is_div, f3, w, a, b);
        early = EARLY && is_trivial_div(is_div, f3, w, a, b);
        if (early)       lat = 2;
        else if (is_div) lat = (w ? DIV_LAT / 2 : DIV_LAT) + 1;
        else             lat = MUL_LAT + 1;
        e.res  = expv;
        e.vcyc = cyc + lat;
        e.name = nm;
        sb_q.push_back(e);
        mul_en = !is_div; div_en = is_div; funct3 = f3; word = w; rs1 = a; rs2 = b;
        globstall = 1'b0;
        dp_result = {$urandom, $urandom};
        for (int k = 1; k <= lat + stall + 1; k++) begin
            tick();
            mul_en = 1'b0; div_en = 1'b0;
            funct3 = 3'($urandom_range(0, 7)); word = 1'($urandom_range(0, 1));
            rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
            if (k >= lat - 1) dp_result = w ? {$urandom, expv[31:0]} : expv;
            else              dp_result = {$urandom, $urandom};
            if (k < lat) globstall = 1'($urandom_range(0, 1));
            else         globstall = (k < lat + stall);
            if (k == 1) begin
                check({nm, "_dp_start"}, 64'(dp_start), 64'(!early));
                check({nm, "_seldiv"}, 64'(dp_seldiv), 64'(is_div));
                check({nm, "_busy"}, 64'(busy), 64'd1);
            end
            if (k == 2) check({nm, "_dp_start_pulse"}, 64'(dp_start), 64'd0);
        end
        globstall = 1'b0;
        check({nm, "_idle_valid"}, 64'(valid), 64'd0);
        check({nm, "_idle_busy"}, 64'(busy), 64'd0);
        last_res = expv;
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1 && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no completion", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.res);
                check({mon_e.name, "_valid_cycle"}, 64'(cyc), 64'(mon_e.vcyc));
                held_res = mon_e.res;
            end
        end else if (valid === 1'b1 && prev_valid) begin
            check("result_hold", result, held_res);
        end
        prev_valid = (valid === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: no finish by time %0t, expected finish before 300000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          d, w;
        logic [2:0]  f;
        logic [63:0] a, b;
        rst = 1'b1; mul_en = 1'b0; div_en = 1'b0; funct3 = 3'd0; word = 1'b0;
        rs1 = 64'd0; rs2 = 64'd0; flush = 1'b0; globstall = 1'b0; dp_result = 64'd0;
        repeat (3) tick();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_start", 64'(dp_start), 64'd0);
        check("rst_seldiv", 64'(dp_seldiv), 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b0;
        tick();

        run_op(1'b0, F3_MUL,  1'b0, 64'd3, 64'd5, 0, "mul_3x5");
        run_op(1'b1, F3_DIVU, 1'b0, 64'd100, 64'd7, 0, "divu_100_7");
        run_op(1'b1, F3_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5, "divw_stall5");
        run_op(1'b1, F3_DIV,  1'b0, 64'd12345, 64'd0, 0, "div_by_zero");
        run_op(1'b1, F3_REMU, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 1, "remu_by_zero");
        run_op(1'b1, F3_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div_ovf");
        run_op(1'b1, F3_REM,  1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, "remw_ovf");
        run_op(1'b0, F3_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h7FFF_FFFF_FFFF_FFFF, 0, "mulh_neg");
        run_op(1'b0, F3_MUL,  1'b1, 64'hDEAD_0000_0001_0000, 64'h0000_BEEF_0001_0000, 2, "mulw_wrap");

        // flush with the divide counter at 10
        div_en = 1'b1; funct3 = F3_DIVU; word = 1'b0; rs1 = 64'd1000; rs2 = 64'd3;
        for (int k = 1; k <= DIV_LAT - 9; k++) begin
            tick();
            div_en = 1'b0;
            dp_result = {$urandom, $urandom};
            globstall = 1'($urandom_range(0, 1));
        end
        globstall = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_seldiv", 64'(dp_seldiv), 64'd0);
        check("flush_result_kept", result, last_res);
        repeat (3) tick();
        run_op(1'b0, F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 0, "mul_after_flush");

        // request arriving together with flush is dropped
        mul_en = 1'b1; flush = 1'b1; rs1 = 64'd9; rs2 = 64'd9;
        tick();
        mul_en = 1'b0; flush = 1'b0;
        check("flush_req_busy", 64'(busy), 64'd0);
        check("flush_req_dp_start", 64'(dp_start), 64'd0);
        tick();

        // reset mid-multiply, with a competing request and flush
        mul_en = 1'b1; funct3 = F3_MUL; rs1 = 64'd11; rs2 = 64'd13;
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; mul_en = 1'b0;
        check("rstmid_valid", 64'(valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_dp_start", 64'(dp_start), 64'd0);
        check("rstmid_seldiv", 64'(dp_seldiv), 64'd0);
        check("rstmid_result", result, 64'd0);
        last_res = 64'd0;
        repeat (5) tick();

        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (d)      f = 3'(4 + $urandom_range(0, 3));
            else if (w) f = F3_MUL;
            else        f = 3'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            run_op(d, f, w, a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        repeat (2) tick();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: %0d ops never completed, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
